freq_div_ctrl: RTL and testbench
================================

FREQ_DIV_CTRL -- requirements
Module: freq_div_ctrl

Interface
REQ-001 Parameter SIZE, default 8 (shared `SIZE), width of every division-factor field.
REQ-002 Parameter RST_CYCLES, default 2, number of cycles divider reset is held; legal range 1..15.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous reset, active-low.
REQ-005 req_valid  input  1  new division factor offered.
REQ-006 req_n  input  SIZE  requested division factor.
REQ-007 req_ready  output  1  controller can accept a request this cycle.
REQ-008 div_out  input  1  divided clock fed back from the active divider (asynchronous to clk phase).
REQ-009 div_n  output  SIZE  division factor driven to the even/odd dividers.
REQ-010 div_reset  output  1  active-high synchronous reset to the dividers.
REQ-011 even_en / odd_en / bypass  output  1 each  one-hot path select: even divider, odd divider, N=1 clock pass-through.
REQ-012 locked  output  1  divider running at div_n with a stable output.
REQ-013 err  output  1  one-cycle pulse: rejected request.

Function
REQ-014 States: IDLE (unconfigured), DRAIN, HOLD, SETTLE, RUN; binary-encoded.
REQ-015 Handshake: request accepted on a cycle with req_valid=1 and req_ready=1; req_ready=1 only in IDLE and RUN.
REQ-016 Accepted req_n=0: err=1 for exactly the next cycle; state, div_n, and enables unchanged.
REQ-017 Accepted req_n equal to div_n while in RUN: no-op, locked stays 1, no err.
REQ-018 Other accepted request: req_n latched into pending register; IDLE -> HOLD, RUN -> DRAIN; locked=0 from the next cycle.
REQ-019 div_out passes through a 2-flop synchronizer before use.
REQ-020 DRAIN: exit to HOLD when synchronized div_out is 0 for 2 consecutive cycles, or when the timeout counter reaches 2*div_n+4, whichever comes first.
REQ-021 Timeout arithmetic uses SIZE+2 bits; no wrap for div_n = 2^SIZE-1.
REQ-022 HOLD: div_reset=1, all enables 0, div_n <= pending on HOLD entry; stay exactly RST_CYCLES cycles, then go to SETTLE.
REQ-023 SETTLE: div_reset=0; enable select from div_n: bypass if div_n=1, odd_en if div_n odd and >1, even_en if div_n even.
REQ-024 SETTLE lasts 2*div_n cycles (SIZE+1-bit counter), then go to RUN.
REQ-025 RUN: locked=1, req_ready=1; enables held.
REQ-026 Exactly one of even_en/odd_en/bypass is 1 in SETTLE and RUN; all are 0 in IDLE, DRAIN, and HOLD.
REQ-027 req_valid in DRAIN/HOLD/SETTLE is ignored (not accepted, no err); the requester must hold it until ready.
REQ-028 A request accepted in the same cycle as a SETTLE->RUN transition cannot occur (req_ready=0 in SETTLE).

Reset
REQ-029 reset=0 at a clk edge forces, on that edge: state=IDLE, div_n=1, div_reset=1, even_en=odd_en=bypass=0, locked=0, req_ready=1, err=0, pending=0, and all counters and synchronizer flops=0.
REQ-030 Reset mid-operation (any state) aborts the sequence with no further outputs changes beyond REQ-029.
REQ-031 div_reset stays 1 in IDLE until the first legal request reaches SETTLE.

Structure
REQ-032 Shared defines file holds SIZE and the state encodings (ST_IDLE..ST_RUN).
REQ-033 One sub-module, freq_div_sync: 2-flop synchronizer with clk and reset ports, instantiated once for div_out.
REQ-034 Controller FSM, pending register, and counters reside in freq_div_ctrl; no divider logic is included.

Verification
REQ-035 Reset, then request 6 -> HOLD for 2 cycles with div_n=6, even_en=1 after HOLD, locked=1 exactly 12 cycles after SETTLE entry.
REQ-036 From RUN at 6, request 5 with div_out forced 1 -> DRAIN times out after 16 cycles, then odd_en=1, locked after a further 2+10 cycles.
REQ-037 Request 0 in RUN -> err pulse of 1 cycle, div_n unchanged, locked stays 1.
REQ-038 Request 1 -> bypass=1, even_en=odd_en=0, locked after 2 SETTLE cycles; re-request 1 -> no-op.
REQ-039 reset=0 asserted during SETTLE -> next cycle all outputs at REQ-029 values; req_valid held during HOLD is not accepted until RUN.
REQ-040 SIZE=8, request 255 -> timeout and settle counters do not wrap; locked after exactly 510 SETTLE cycles.

Source files
------------

// File: rtl/freq_div_ctrl_pkg.sv
// Shared constants, state encoding and path-select helper for the clock-divider controller.
package freq_div_ctrl_pkg;

  localparam int DEF_SIZE = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_HOLD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4
  } state_e;

  typedef struct packed {
    logic even_en;
    logic odd_en;
    logic bypass;
  } path_t;

  function automatic path_t path_sel(input logic is_one, input logic is_odd);
    path_t p;
    p = '0;
    if (is_one)      p.bypass  = 1'b1;
    else if (is_odd) p.odd_en  = 1'b1;
    else             p.even_en = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/freq_div_sync.sv
// Two-flop synchronizer for the divided clock fed back from the dividers.
module freq_div_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/freq_div_ctrl.sv
// Division-factor controller: accepts a new factor, drains the running divider,
// resets it, selects the even/odd/bypass path and reports lock after settling.
module freq_div_ctrl
  import freq_div_ctrl_pkg::*;
#(
  parameter int SIZE       = DEF_SIZE,
  parameter int RST_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [SIZE-1:0] req_n,
  output logic            req_ready,
  input  logic            div_out,
  output logic [SIZE-1:0] div_n,
  output logic            div_reset,
  output logic            even_en,
  output logic            odd_en,
  output logic            bypass,
  output logic            locked,
  output logic            err
);

  state_e          state_q, state_d;
  logic [SIZE-1:0] div_n_q, div_n_d;
  logic [SIZE-1:0] pend_q, pend_d;
  logic [SIZE+1:0] tmo_q, tmo_d;
  logic [SIZE:0]   settle_q, settle_d;
  logic [3:0]      hold_q, hold_d;
  logic [1:0]      zero_q, zero_d;
  path_t           path_q, path_d;
  logic            div_reset_q, div_reset_d;
  logic            locked_q, locked_d;
  logic            req_ready_q, req_ready_d;
  logic            err_q, err_d;

  logic            div_sync;
  logic            accept;
  logic [SIZE+1:0] tmo_lim;
  logic [SIZE:0]   settle_lim;

  freq_div_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (div_out),
    .q     (div_sync)
  );

  // Limits are widened so 2*div_n+4 and 2*div_n never wrap at the largest factor.
  assign tmo_lim    = {1'b0, div_n_q, 1'b0} + (SIZE+2)'(4);
  assign settle_lim = {div_n_q, 1'b0};
  assign accept     = req_valid && req_ready_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    div_n_d  = div_n_q;
    pend_d   = pend_q;
    tmo_d    = '0;
    settle_d = '0;
    hold_d   = '0;
    zero_d   = '0;
    err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (accept) begin
          if (req_n == '0) begin
            err_d = 1'b1;
          end else if (!(state_q == ST_RUN && req_n == div_n_q)) begin
            pend_d  = req_n;
            state_d = (state_q == ST_IDLE) ? ST_HOLD : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        tmo_d  = tmo_q + 1'b1;
        zero_d = div_sync ? 2'd0 : zero_q + 2'd1;
        if (zero_d == 2'd2 || tmo_d == tmo_lim) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_d == 4'(RST_CYCLES)) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        settle_d = settle_q + 1'b1;
        if (settle_d == settle_lim) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_HOLD && state_q != ST_HOLD) div_n_d = pend_d;

    // Outputs are registered from the next state so they line up with state_q.
    req_ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN);
    locked_d    = (state_d == ST_RUN);
    div_reset_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
    path_d      = ((state_d == ST_SETTLE) || (state_d == ST_RUN))
                  ? path_sel(div_n_d == SIZE'(1), div_n_d[0]) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      div_n_q     <= SIZE'(1);
      pend_q      <= '0;
      tmo_q       <= '0;
      settle_q    <= '0;
      hold_q      <= '0;
      zero_q      <= '0;
      path_q      <= '0;
      div_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      req_ready_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_n_q     <= div_n_d;
      pend_q      <= pend_d;
      tmo_q       <= tmo_d;
      settle_q    <= settle_d;
      hold_q      <= hold_d;
      zero_q      <= zero_d;
      path_q      <= path_d;
      div_reset_q <= div_reset_d;
      locked_q    <= locked_d;
      req_ready_q <= req_ready_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign div_n     = div_n_q;
  assign div_reset = div_reset_q;
  assign even_en   = path_q.even_en;
  assign odd_en    = path_q.odd_en;
  assign bypass    = path_q.bypass;
  assign locked    = locked_q;
  assign err       = err_q;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Self-checking bench for freq_div_ctrl: each request is predicted as a timeline of
// drain / hold / settle / run phases whose lengths come from plain arithmetic.
module tb_freq_div_ctrl;

  localparam int SIZE       = 8;
  localparam int RST_CYCLES = 2;
  localparam int PAT_LEN    = 2048;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic [SIZE-1:0] req_n;
  logic            req_ready;
  logic            div_out;
  logic [SIZE-1:0] div_n;
  logic            div_reset;
  logic            even_en;
  logic            odd_en;
  logic            bypass;
  logic            locked;
  logic            err;

  freq_div_ctrl #(.SIZE(SIZE), .RST_CYCLES(RST_CYCLES)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_n     (req_n),
    .req_ready (req_ready),
    .div_out   (div_out),
    .div_n     (div_n),
    .div_reset (div_reset),
    .even_en   (even_en),
    .odd_en    (odd_en),
    .bypass    (bypass),
    .locked    (locked),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef enum {PH_IDLE, PH_DRAIN, PH_HOLD, PH_SETTLE, PH_RUN} phase_e;

  typedef struct packed {
    logic            ready;
    logic            dreset;
    logic            even;
    logic            odd;
    logic            byp;
    logic            lock;
    logic            err;
    logic [SIZE-1:0] divn;
  } obs_t;

  int errors = 0;
  int checks = 0;
  int cur_n  = 1;
  bit pat [0:PAT_LEN-1];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    return obs_t'{req_ready, div_reset, even_en, odd_en, bypass, locked, err, div_n};
  endfunction

  function automatic obs_t expect_obs(input phase_e ph, input int n_old, input int n_new);
    obs_t e;
    e = '0;
    case (ph)
      PH_IDLE:  begin e.ready = 1'b1; e.dreset = 1'b1; e.divn = SIZE'(n_old); end
      PH_DRAIN: e.divn = SIZE'(n_old);
      PH_HOLD:  begin e.dreset = 1'b1; e.divn = SIZE'(n_new); end
      default: begin
        e.divn = SIZE'(n_new);
        e.byp  = (n_new == 1);
        e.odd  = (n_new > 1) && (n_new % 2 == 1);
        e.even = (n_new % 2 == 0);
        if (ph == PH_RUN) begin e.ready = 1'b1; e.lock = 1'b1; end
      end
    endcase
    return e;
  endfunction

  function automatic phase_e phase_at(input int j, input int d, input int n);
    if (j < d)                    return PH_DRAIN;
    if (j < d + RST_CYCLES)       return PH_HOLD;
    if (j < d + RST_CYCLES + 2*n) return PH_SETTLE;
    return PH_RUN;
  endfunction

  task automatic fill_pat(input bit random_mode);
    for (int i = 0; i < PAT_LEN; i++)
      pat[i] = random_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  // pat[i] is the div_out value sampled at the edge i-1 relative to acceptance,
  // so the synchronized value seen in drain cycle k is pat[k-1].
  task automatic request(input int n, input bit from_run, input int abort_settle);
    int  n_old;
    int  d;
    int  last;
    bit  found;
    n_old = cur_n;
    d     = 0;
    if (from_run) begin
      d     = 2*n_old + 4;
      found = 1'b0;
      for (int k = 2; k < 2*n_old + 4; k++)
        if (!found && !pat[k-2] && !pat[k-1]) begin d = k; found = 1'b1; end
    end
    div_out = pat[0];
    step();
    req_valid = 1'b1; req_n = SIZE'(n); div_out = pat[1];
    step();
    req_valid = 1'b0;
    last = d + RST_CYCLES + 2*n;
    for (int j = 0; j <= last; j++) begin
      check($sformatf("req%0d_c%0d", n, j), 32'(sample()),
            32'(expect_obs(phase_at(j, d, n), n_old, n)));
      if (abort_settle >= 0 && j == d + RST_CYCLES + abort_settle) begin
        reset = 1'b0;
        step();
        check("abort_reset", 32'(sample()), 32'(expect_obs(PH_IDLE, 1, 1)));
        step();
        check("abort_reset_hold", 32'(sample()), 32'(expect_obs(PH_IDLE, 1, 1)));
        reset = 1'b1;
        cur_n = 1;
        return;
      end
      if (j < last) begin
        div_out = (j + 2 < PAT_LEN) ? pat[j+2] : 1'b1;
        step();
      end
    end
    cur_n = n;
  endtask

  initial begin
    obs_t e;
    int   n;
    int   t;

    reset = 1'b0; req_valid = 1'b0; req_n = '0; div_out = 1'b0;
    step();
    step();
    check("reset_state", 32'(sample()), 32'(expect_obs(PH_IDLE, 1, 1)));
    reset = 1'b1;
    step();
    check("idle_state", 32'(sample()), 32'(expect_obs(PH_IDLE, 1, 1)));

    // First request from the unconfigured state goes straight to HOLD.
    fill_pat(1'b0);
    request(6, 1'b0, -1);

    // Divider output stuck high: drain must end on the timeout.
    fill_pat(1'b0);
    request(5, 1'b1, -1);

    // A zero factor is rejected with a single-cycle error pulse.
    req_valid = 1'b1; req_n = '0;
    step();
    req_valid = 1'b0;
    e = expect_obs(PH_RUN, cur_n, cur_n);
    e.err = 1'b1;
    check("err_pulse", 32'(sample()), 32'(e));
    step();
    check("err_clear", 32'(sample()), 32'(expect_obs(PH_RUN, cur_n, cur_n)));

    fill_pat(1'b1);
    request(1, 1'b1, -1);

    // Same factor again is a no-op.
    req_valid = 1'b1; req_n = SIZE'(1);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("noop_c%0d", i), 32'(sample()), 32'(expect_obs(PH_RUN, 1, 1)));
      step();
    end

    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 40);
      if (n == cur_n) n = (cur_n % 40) + 1;
      fill_pat(1'b1);
      request(n, 1'b1, -1);
    end

    // Reset pulled low in the middle of SETTLE.
    fill_pat(1'b1);
    request(7, 1'b1, 3);

    // A request held through HOLD/SETTLE is only taken once RUN is reached.
    div_out = 1'b1;
    req_valid = 1'b1; req_n = SIZE'(3);
    step();
    req_n = SIZE'(4);
    for (int j = 0; j <= RST_CYCLES + 6; j++) begin
      check($sformatf("held_c%0d", j), 32'(sample()), 32'(expect_obs(phase_at(j, 0, 3), 1, 3)));
      step();
    end
    check("held_accept", 32'(sample()), 32'(expect_obs(PH_DRAIN, 3, 4)));
    req_valid = 1'b0;
    div_out   = 1'b0;
    t = 0;
    while (!locked && t < 200) begin
      step();
      t++;
    end
    check("held_lock", 32'(sample()), 32'(expect_obs(PH_RUN, 4, 4)));
    cur_n = 4;

    // Largest factors: the timeout and settle counters must not wrap.
    fill_pat(1'b0);
    request(255, 1'b1, -1);
    fill_pat(1'b0);
    request(254, 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
